// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - opcode, funct and ALUOp encodings shared by decode logic
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // ori is the only logical-immediate op, so it alone zero-extends.
    function automatic logic [31:0] imm_extend(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/main_control.sv
// rtl/main_control.sv - combinational opcode/funct decoder producing datapath controls
module main_control
    import cpu_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       RegDst,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       Jump,
    output logic       JumpReg,
    output logic [1:0] ALUOp,
    output logic       Illegal
);

    always_comb begin
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        JumpReg  = 1'b0;
        ALUOp    = ALUOP_ADD;
        Illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        RegDst   = 1'b1;
                        RegWrite = 1'b1;
                        ALUOp    = ALUOP_FUNCT;
                    end
                    // jr keeps the R-type datapath setting but must not write back.
                    FN_JR: begin
                        RegDst  = 1'b1;
                        JumpReg = 1'b1;
                        ALUOp   = ALUOP_FUNCT;
                    end
                    default: Illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ALUSrc   = 1'b1;
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            OP_SW: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OP_BEQ: begin
                Branch = 1'b1;
                ALUOp  = ALUOP_SUB;
            end
            OP_ADDI: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
            end
            OP_ORI: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                ALUOp    = ALUOP_OR;
            end
            OP_J:    Jump = 1'b1;
            OP_JAL: begin
                Jump     = 1'b1;
                RegWrite = 1'b1;
            end
            default: Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - decode stage: instruction decoder plus 32x32 register file
module decode_regfile
    import cpu_defs::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Inst,
    input  logic [31:0] PC_plus4,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] ImmExt,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        Branch,
    output logic        Jump,
    output logic        JumpReg,
    output logic [1:0]  ALUOp,
    output logic        Illegal,
    output logic [31:0] reg31
);

    logic [31:0] regs_q [0:31];
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [4:0]  wr_addr_d;
    logic [31:0] wr_data_d;
    logic        is_jal;
    logic        unused_shamt;

    assign opcode       = Inst[31:26];
    assign rs           = Inst[25:21];
    assign rt           = Inst[20:16];
    assign rd           = Inst[15:11];
    assign unused_shamt = ^Inst[10:6];
    assign is_jal       = (opcode == OP_JAL);

    main_control u_main_control (
        .opcode   (opcode),
        .funct    (Inst[5:0]),
        .RegDst   (RegDst),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .Jump     (Jump),
        .JumpReg  (JumpReg),
        .ALUOp    (ALUOp),
        .Illegal  (Illegal)
    );

    assign ImmExt = imm_extend(Inst[15:0], opcode == OP_ORI);

    assign wr_addr_d = is_jal ? 5'd31 : (RegDst ? rd : rt);
    assign wr_data_d = is_jal ? PC_plus4 : WriteData;

    // r0 is forced on the read side, so the array slot is never relied on.
    assign ReadData1 = (rs == 5'd0) ? 32'h0 : regs_q[rs];
    assign ReadData2 = (rt == 5'd0) ? 32'h0 : regs_q[rt];
    assign reg31     = regs_q[31];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (RegWrite && (wr_addr_d != 5'd0)) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_decode_regfile.sv
// tb/tb_decode_regfile.sv - randomized self-checking bench for decode_regfile
module tb_decode_regfile;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Inst, PC_plus4, WriteData;
    logic [31:0] ReadData1, ReadData2, ImmExt, reg31;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump, JumpReg, Illegal;
    logic [1:0]  ALUOp;

    int checks = 0;
    int failures = 0;
    logic [31:0] ref_regs [32];

    always #5 Clock = ~Clock;

    decode_regfile dut (
        .Clock(Clock), .Reset(Reset), .Inst(Inst), .PC_plus4(PC_plus4), .WriteData(WriteData),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .ImmExt(ImmExt),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
        .ALUOp(ALUOp), .Illegal(Illegal), .reg31(reg31)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Expected controls as {RegDst,ALUSrc,MemtoReg,RegWrite,MemWrite,Branch,Jump,JumpReg,ALUOp[1:0],Illegal}
    function automatic logic [10:0] ref_ctrl(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                    return 11'b1001_0000_10_0;
                else if (fn == 6'h08)
                    return 11'b1000_0001_10_0;
                else
                    return 11'b0000_0000_00_1;
            end
            6'h23:   return 11'b0111_0000_00_0;
            6'h2B:   return 11'b0100_1000_00_0;
            6'h04:   return 11'b0000_0100_01_0;
            6'h08:   return 11'b0101_0000_00_0;
            6'h0D:   return 11'b0101_0000_11_0;
            6'h02:   return 11'b0000_0010_00_0;
            6'h03:   return 11'b0001_0010_00_0;
            default: return 11'b0000_0000_00_1;
        endcase
    endfunction

    function automatic logic [31:0] mk_inst(input logic [5:0] op, input logic [4:0] rs_f,
                                            input logic [4:0] rt_f, input logic [15:0] imm);
        return {op, rs_f, rt_f, imm};
    endfunction

    // Apply one instruction, check every output against the model, then clock it in.
    task automatic step(input logic rst, input logic [31:0] inst, input logic [31:0] pc4,
                        input logic [31:0] wd);
        logic [10:0] ec;
        logic [31:0] eimm;
        logic [4:0]  wa;
        Reset = rst; Inst = inst; PC_plus4 = pc4; WriteData = wd;
        #3;
        ec   = ref_ctrl(inst[31:26], inst[5:0]);
        eimm = (inst[31:26] == 6'h0D) ? {16'h0, inst[15:0]} : 32'(signed'(inst[15:0]));
        check("ctrl", 32'({RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump, JumpReg,
                           ALUOp, Illegal}), 32'(ec));
        check("immext", ImmExt, eimm);
        check("rd1", ReadData1, (inst[25:21] == 0) ? 32'h0 : ref_regs[inst[25:21]]);
        check("rd2", ReadData2, (inst[20:16] == 0) ? 32'h0 : ref_regs[inst[20:16]]);
        check("reg31", reg31, ref_regs[31]);
        @(posedge Clock);
        if (rst) begin
            foreach (ref_regs[i]) ref_regs[i] = 32'h0;
        end else if (ec[7]) begin
            wa = (inst[31:26] == 6'h03) ? 5'd31 : (ec[10] ? inst[15:11] : inst[20:16]);
            if (wa != 0) ref_regs[wa] = (inst[31:26] == 6'h03) ? pc4 : wd;
        end
        #1;
    endtask

    initial begin
        logic [5:0] ops [12];
        logic [5:0] fns [7];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h02, 6'h03, 6'h3F, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h3F};
        foreach (ref_regs[i]) ref_regs[i] = 32'h0;
        Reset = 1'b1; Inst = 32'h0; PC_plus4 = 32'h0; WriteData = 32'h0;
        @(posedge Clock); #1;
        check("reset_reg31", reg31, 32'h0);

        // r5 = 0x1234, then reset must clear it
        step(1'b0, mk_inst(6'h08, 5'd0, 5'd5, 16'h1234), 32'h0, 32'h1234);
        check("r5_written", ref_regs[5] == 32'h1234 ? 32'h1 : 32'h0, 32'h1);
        step(1'b1, mk_inst(6'h08, 5'd0, 5'd5, 16'h0001), 32'h0, 32'h5555);
        Inst = mk_inst(6'h00, 5'd5, 5'd0, 16'h0020); #1;
        check("r5_after_reset", ReadData1, 32'h0);
        check("reg31_after_reset", reg31, 32'h0);

        // addi r8,r0,0xFFFF
        Inst = mk_inst(6'h08, 5'd0, 5'd8, 16'hFFFF); #1;
        check("addi_imm", ImmExt, 32'hFFFFFFFF);
        check("addi_alusrc_regwrite", {ALUSrc, RegWrite}, 32'h3);
        step(1'b0, mk_inst(6'h08, 5'd0, 5'd8, 16'hFFFF), 32'h0, 32'hFFFFFFFF);
        Inst = mk_inst(6'h00, 5'd8, 5'd0, 16'h0020); #1;
        check("addi_r8", ReadData1, 32'hFFFFFFFF);

        // ori imm 0x8000
        Inst = mk_inst(6'h0D, 5'd1, 5'd2, 16'h8000); #1;
        check("ori_imm", ImmExt, 32'h00008000);
        check("ori_aluop", ALUOp, 32'h3);

        // jal then jr
        step(1'b0, {6'h03, 26'h0000010}, 32'h0000000D, 32'h0);
        check("jal_reg31", reg31, 32'h0000000D);
        Inst = mk_inst(6'h00, 5'd31, 5'd0, 16'h0008); #1;
        check("jr_jumpreg_regwrite", {JumpReg, RegWrite}, 32'h2);

        // add with rd=0, and same-cycle read of rd being written
        step(1'b0, mk_inst(6'h00, 5'd0, 5'd0, {5'd0, 5'd0, 6'h20}), 32'h0, 32'hAAAA);
        Inst = mk_inst(6'h00, 5'd0, 5'd0, 16'h0020); #1;
        check("r0_zero", ReadData1, 32'h0);
        Inst = mk_inst(6'h00, 5'd8, 5'd0, {5'd8, 5'd0, 6'h20}); WriteData = 32'h1357; #1;
        check("no_bypass", ReadData1, 32'hFFFFFFFF);
        step(1'b0, Inst, 32'h0, 32'h1357);
        check("add_r8_after", ReadData1, 32'h1357);

        // illegal opcode / funct: controls 0, no writes
        Inst = mk_inst(6'h3F, 5'd0, 5'd9, 16'h0); #1;
        check("illegal_op", {RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump, JumpReg,
                             ALUOp, Illegal}, 32'h1);
        step(1'b0, mk_inst(6'h3F, 5'd0, 5'd9, 16'h0), 32'h0, 32'hDEAD);
        step(1'b0, mk_inst(6'h00, 5'd0, 5'd9, {5'd9, 5'd0, 6'h3F}), 32'h0, 32'hBEEF);
        Inst = mk_inst(6'h00, 5'd9, 5'd0, 16'h0020); #1;
        check("illegal_nowrite", ReadData1, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 11)];
            if (op == 6'h3F) op = 6'($urandom);
            fn = fns[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            step(($urandom_range(0, 59) == 0),
                 {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn},
                 $urandom, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_regfile.md
DECODE_REGFILE -- requirements
Module: decode_regfile

Interface
REQ-001 The block SHALL have port Clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset sampled on the rising edge of Clock.
REQ-003 The block SHALL have port Inst, input, 32 bits: the current instruction from the fetch stage.
REQ-004 The block SHALL have port PC_plus4, input, 32 bits: the PC+4 of the current instruction, written to r31 by jal.
REQ-005 The block SHALL have port WriteData, input, 32 bits: the ALU or memory write-back value for the current instruction.
REQ-006 The block SHALL have ports ReadData1 and ReadData2, outputs, 32 bits each: register-file values addressed by rs and rt.
REQ-007 The block SHALL have port ImmExt, output, 32 bits: the extended 16-bit immediate.
REQ-008 The block SHALL have outputs RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump and JumpReg, 1 bit each: datapath controls.
REQ-009 The block SHALL have port ALUOp, output, 2 bits: 00 add, 01 sub, 10 use funct, 11 or.
REQ-010 The block SHALL have port Illegal, output, 1 bit: high for an undecodable opcode or funct.
REQ-011 The block SHALL have port reg31, output, 32 bits: the current r31 contents, fed to fetch for jr.

Function
REQ-012 The block SHALL decode these opcodes: R-type 0x00 (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, ori 0x0D, j 0x02, jal 0x03.
REQ-013 Control SHALL be: R-type RegDst=1, RegWrite=1, ALUOp=10; lw ALUSrc=1, MemtoReg=1, RegWrite=1; sw ALUSrc=1, MemWrite=1; beq Branch=1, ALUOp=01; addi ALUSrc=1, RegWrite=1; ori ALUSrc=1, RegWrite=1, ALUOp=11; j Jump=1; jal Jump=1, RegWrite=1. All unlisted controls SHALL be 0.
REQ-014 jr SHALL assert JumpReg=1 with RegWrite=0.
REQ-015 An unknown opcode, or an unknown funct under R-type, SHALL drive all controls to 0 and Illegal=1, so the instruction behaves as a NOP.
REQ-016 ImmExt SHALL be zero-extended for ori and sign-extended from Inst[15] for all other opcodes.
REQ-017 Reads SHALL be combinational: ReadData1=R[Inst[25:21]], ReadData2=R[Inst[20:16]]; reading r0 SHALL return 0.
REQ-018 The write address SHALL be 31 for jal, rd (Inst[15:11]) when RegDst=1, and rt (Inst[20:16]) otherwise.
REQ-019 The write data SHALL be PC_plus4 for jal and WriteData otherwise.
REQ-020 The write SHALL occur on the rising edge when RegWrite=1, Reset=0 and the write address is nonzero; writes to r0 SHALL be discarded.
REQ-021 There SHALL be no same-cycle bypass: a read of the register being written returns the old value until after the edge.
REQ-022 reg31 SHALL reflect R[31] directly, with zero latency after the writing edge.

Reset
REQ-023 On a rising edge with Reset=1, all 32 registers SHALL clear to 0, so reg31, ReadData1 and ReadData2 read 0.
REQ-024 Reset SHALL take priority over a simultaneous write, and a write in progress during reset SHALL be lost.
REQ-025 Decode outputs SHALL be purely combinational from Inst, with no reset dependence.

Structure
REQ-026 Opcode constants, funct constants and ALUOp encodings SHALL reside in a shared package, cpu_defs.
REQ-027 Decoding SHALL be one combinational sub-module, main_control (inputs opcode and funct; outputs the controls and Illegal); the register array SHALL live in decode_regfile.

Verification
REQ-028 Reset=1 for one edge after a prior write of r5=0x1234 -> ReadData1 for rs=5 is 0 and reg31=0.
REQ-029 Inst=addi r8,r0,0xFFFF with WriteData=0xFFFFFFFF -> ImmExt=0xFFFFFFFF, ALUSrc=1, RegWrite=1; after the edge, a read of r8 gives 0xFFFFFFFF.
REQ-030 Inst=ori with imm 0x8000 -> ImmExt=0x00008000, ALUOp=11.
REQ-031 Inst=jal with PC_plus4=0x0000000D -> after the edge reg31=0x0000000D; a following jr gives JumpReg=1 and RegWrite=0.
REQ-032 R-type add with rd=0 and WriteData=0xAAAA -> r0 still reads 0; a same-cycle read of the rd being written returns the old value.
REQ-033 Opcode 0x3F, or R-type funct 0x3F -> Illegal=1, all controls 0, and no register changes.
